// File: rtl/mem_port_arbiter.sv
// Arbitrates one mem_system between the fetch port (read-only) and the data port (read/write).
// Latches the winning request for the whole transaction, guards fetch against starvation, times out hangs.
module mem_port_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned TIMEOUT      = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        IReq,
  input  logic [15:0] IAddr,
  input  logic        DRd,
  input  logic        DWr,
  input  logic [15:0] DAddr,
  input  logic [15:0] DDataIn,
  input  logic        DDump,
  output logic [15:0] IDataOut,
  output logic        IDone,
  output logic        IStall,
  output logic [15:0] DDataOut,
  output logic        DDone,
  output logic        DStall,
  output logic        err,
  output logic [15:0] M_Addr,
  output logic [15:0] M_DataIn,
  output logic        M_Rd,
  output logic        M_Wr,
  output logic        M_Dump,
  input  logic [15:0] M_DataOut,
  input  logic        M_Done,
  input  logic        M_err
);

  localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {StIdle, StIBusy, StDBusy} state_e;

  state_e        state_q;
  logic [15:0]   addr_q;
  logic [15:0]   data_q;
  logic          rd_q;
  logic          wr_q;
  logic [SW-1:0] starve_q;
  logic [7:0]    wd_q;
  logic          timeout_q;

  logic dreq;
  logic busy;
  logic d_win;
  logic timeout_hit;
  logic finish;

  assign dreq        = DRd | DWr;
  assign busy        = (state_q != StIdle);
  assign d_win       = dreq && (starve_q < SW'(STARVE_LIMIT));
  // M_Done on the last watchdog cycle still counts as a normal completion.
  assign timeout_hit = busy && !M_Done && (wd_q == 8'(TIMEOUT - 1));
  assign finish      = busy && (M_Done || timeout_hit);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      addr_q    <= '0;
      data_q    <= '0;
      rd_q      <= 1'b0;
      wr_q      <= 1'b0;
      starve_q  <= '0;
      wd_q      <= '0;
      timeout_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (d_win) begin
            state_q  <= StDBusy;
            addr_q   <= DAddr;
            data_q   <= DDataIn;
            rd_q     <= DRd;
            wr_q     <= DWr;
            wd_q     <= '0;
            starve_q <= IReq ? starve_q + SW'(1) : '0;
          end else if (IReq) begin
            state_q  <= StIBusy;
            addr_q   <= IAddr;
            data_q   <= '0;
            rd_q     <= 1'b1;
            wr_q     <= 1'b0;
            wd_q     <= '0;
            starve_q <= '0;
          end
        end
        StIBusy, StDBusy: begin
          if (finish) begin
            state_q <= StIdle;
            if (timeout_hit) timeout_q <= 1'b1;
          end else begin
            wd_q <= wd_q + 8'd1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_comb begin
    M_Addr   = '0;
    M_DataIn = '0;
    M_Rd     = 1'b0;
    M_Wr     = 1'b0;
    if (busy) begin
      M_Addr   = addr_q;
      M_DataIn = data_q;
      M_Rd     = rd_q;
      M_Wr     = wr_q;
    end
    IDone    = (state_q == StIBusy) && finish;
    DDone    = (state_q == StDBusy) && finish;
    // A watchdog abort returns zero data.
    IDataOut = (IDone && M_Done) ? M_DataOut : '0;
    DDataOut = (DDone && M_Done) ? M_DataOut : '0;
  end

  assign IStall = IReq & ~IDone;
  assign DStall = dreq & ~DDone;
  assign M_Dump = DDump;
  assign err    = timeout_q | (M_err & busy);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus randomized transactions against a
// transaction-level model of the arbitration rules.
module tb_mem_port_arbiter;

  localparam int unsigned STARVE_LIMIT = 4;
  localparam int unsigned TIMEOUT      = 64;

  logic        clk = 1'b0;
  logic        rst;
  logic        IReq, DRd, DWr, DDump;
  logic [15:0] IAddr, DAddr, DDataIn;
  logic [15:0] IDataOut, DDataOut;
  logic        IDone, IStall, DDone, DStall, err;
  logic [15:0] M_Addr, M_DataIn, M_DataOut;
  logic        M_Rd, M_Wr, M_Dump, M_Done, M_err;

  int checks = 0;
  int errors = 0;

  mem_port_arbiter #(
    .STARVE_LIMIT(STARVE_LIMIT),
    .TIMEOUT     (TIMEOUT)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .IReq     (IReq),
    .IAddr    (IAddr),
    .DRd      (DRd),
    .DWr      (DWr),
    .DAddr    (DAddr),
    .DDataIn  (DDataIn),
    .DDump    (DDump),
    .IDataOut (IDataOut),
    .IDone    (IDone),
    .IStall   (IStall),
    .DDataOut (DDataOut),
    .DDone    (DDone),
    .DStall   (DStall),
    .err      (err),
    .M_Addr   (M_Addr),
    .M_DataIn (M_DataIn),
    .M_Rd     (M_Rd),
    .M_Wr     (M_Wr),
    .M_Dump   (M_Dump),
    .M_DataOut(M_DataOut),
    .M_Done   (M_Done),
    .M_err    (M_err)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled just after the falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    IReq = 0; DRd = 0; DWr = 0; DDump = 0;
    IAddr = '0; DAddr = '0; DDataIn = '0;
    M_DataOut = '0; M_Done = 0; M_err = 0;
  endtask

  task automatic test_reset();
    rst = 1; DDump = 1; #1;
    checks++;
    if (M_Rd !== 0 || M_Wr !== 0 || M_Addr !== 16'h0 || M_DataIn !== 16'h0) begin
      errors++;
      $display("FAIL reset_mem_if: got rd=%b wr=%b addr=%h din=%h, want 0 0 0000 0000",
               M_Rd, M_Wr, M_Addr, M_DataIn);
    end
    checks++;
    if (IDone !== 0 || DDone !== 0 || IDataOut !== 16'h0 || DDataOut !== 16'h0 || err !== 0) begin
      errors++;
      $display("FAIL reset_outputs: got idone=%b ddone=%b idata=%h ddata=%h err=%b, want zeros",
               IDone, DDone, IDataOut, DDataOut, err);
    end
    checks++;
    if (M_Dump !== 1 || IStall !== 0 || DStall !== 0) begin
      errors++;
      $display("FAIL reset_dump_stall: got dump=%b istall=%b dstall=%b, want 1 0 0",
               M_Dump, IStall, DStall);
    end
    tick();
    rst = 0; DDump = 0; #1;
    checks++;
    if (M_Dump !== 0) begin
      errors++;
      $display("FAIL reset_dump_low: got %b want 0", M_Dump);
    end
  endtask

  task automatic test_single_fetch();
    IReq = 1; IAddr = 16'h0040; #1;
    checks++;
    if (IStall !== 1 || M_Rd !== 0 || M_Addr !== 16'h0) begin
      errors++;
      $display("FAIL fetch_idle: got istall=%b rd=%b addr=%h, want 1 0 0000", IStall, M_Rd, M_Addr);
    end
    tick();
    checks++;
    if (M_Rd !== 1 || M_Wr !== 0 || M_Addr !== 16'h0040 || IStall !== 1 || IDone !== 0) begin
      errors++;
      $display("FAIL fetch_issue: got rd=%b wr=%b addr=%h istall=%b idone=%b, want 1 0 0040 1 0",
               M_Rd, M_Wr, M_Addr, IStall, IDone);
    end
    M_Done = 1; M_DataOut = 16'h1234; #1;
    checks++;
    if (IDone !== 1 || IDataOut !== 16'h1234 || IStall !== 0 || DDone !== 0 || DDataOut !== 0) begin
      errors++;
      $display("FAIL fetch_done: got idone=%b idata=%h istall=%b ddone=%b ddata=%h, want 1 1234 0 0 0",
               IDone, IDataOut, IStall, DDone, DDataOut);
    end
    tick();
    M_Done = 0; M_DataOut = '0; IReq = 0; #1;
    checks++;
    if (M_Rd !== 0 || IDone !== 0 || IStall !== 0) begin
      errors++;
      $display("FAIL fetch_after: got rd=%b idone=%b istall=%b, want 0 0 0", M_Rd, IDone, IStall);
    end
  endtask

  task automatic test_priority();
    logic [15:0] d;
    d = 16'($urandom);
    IReq = 1; IAddr = 16'h0040; DRd = 1; DAddr = 16'h0100;
    tick();
    checks++;
    if (M_Addr !== 16'h0100 || M_Rd !== 1) begin
      errors++;
      $display("FAIL prio_d_first: got addr=%h rd=%b, want 0100 1", M_Addr, M_Rd);
    end
    M_Done = 1; M_DataOut = d; #1;
    checks++;
    if (DDone !== 1 || DDataOut !== d || IDone !== 0 || IDataOut !== 16'h0) begin
      errors++;
      $display("FAIL prio_d_done: got ddone=%b ddata=%h idone=%b idata=%h, want 1 %h 0 0000",
               DDone, DDataOut, IDone, IDataOut, d);
    end
    tick();
    M_Done = 0; DRd = 0; #1;
    checks++;
    if (M_Rd !== 0 || M_Addr !== 16'h0 || IStall !== 1) begin
      errors++;
      $display("FAIL prio_bubble: got rd=%b addr=%h istall=%b, want 0 0000 1", M_Rd, M_Addr, IStall);
    end
    tick();
    checks++;
    if (M_Addr !== 16'h0040 || M_Rd !== 1) begin
      errors++;
      $display("FAIL prio_i_next: got addr=%h rd=%b, want 0040 1", M_Addr, M_Rd);
    end
    M_Done = 1; M_DataOut = ~d; #1;
    checks++;
    if (IDone !== 1 || IDataOut !== ~d || DDone !== 0) begin
      errors++;
      $display("FAIL prio_i_done: got idone=%b idata=%h ddone=%b, want 1 %h 0", IDone, IDataOut, DDone, ~d);
    end
    tick();
    M_Done = 0; IReq = 0;
  endtask

  // D and I both held; model counts consecutive D grants while I waits.
  task automatic test_starvation();
    int starve;
    logic exp_d;
    logic [15:0] d;
    starve = 0;
    IReq = 1; IAddr = 16'h0080; DRd = 1; DAddr = 16'h0300;
    for (int k = 0; k < 6; k++) begin
      exp_d = (starve < int'(STARVE_LIMIT));
      starve = exp_d ? starve + 1 : 0;
      tick();
      checks++;
      if (M_Rd !== 1 || M_Addr !== (exp_d ? DAddr : IAddr)) begin
        errors++;
        $display("FAIL starve_grant%0d: got addr=%h rd=%b, want %h 1",
                 k, M_Addr, M_Rd, exp_d ? DAddr : IAddr);
      end
      d = 16'($urandom);
      M_Done = 1; M_DataOut = d; #1;
      checks++;
      if (DDone !== exp_d || IDone !== !exp_d || (exp_d ? DDataOut : IDataOut) !== d) begin
        errors++;
        $display("FAIL starve_done%0d: got ddone=%b idone=%b ddata=%h idata=%h, want ddone=%b data=%h",
                 k, DDone, IDone, DDataOut, IDataOut, exp_d, d);
      end
      tick();
      M_Done = 0;
      if (!exp_d) IAddr = IAddr + 16'h2;
      DAddr = DAddr + 16'h2;
    end
    IReq = 0; DRd = 0;
  endtask

  task automatic test_hold_latch();
    DWr = 1; DAddr = 16'h0200; DDataIn = 16'hBEEF;
    tick();
    for (int c = 0; c < 4; c++) begin
      DAddr = 16'($urandom); DDataIn = 16'($urandom); #1;
      checks++;
      if (M_Addr !== 16'h0200 || M_DataIn !== 16'hBEEF || M_Wr !== 1 || M_Rd !== 0 ||
          DDone !== 0 || DStall !== 1) begin
        errors++;
        $display("FAIL hold_busy%0d: got addr=%h din=%h wr=%b rd=%b ddone=%b dstall=%b, want 0200 beef 1 0 0 1",
                 c, M_Addr, M_DataIn, M_Wr, M_Rd, DDone, DStall);
      end
      tick();
    end
    M_Done = 1; #1;
    checks++;
    if (DDone !== 1 || DStall !== 0 || M_Addr !== 16'h0200 || M_DataIn !== 16'hBEEF) begin
      errors++;
      $display("FAIL hold_done: got ddone=%b dstall=%b addr=%h din=%h, want 1 0 0200 beef",
               DDone, DStall, M_Addr, M_DataIn);
    end
    tick();
    M_Done = 0; DWr = 0; #1;
    checks++;
    if (M_Wr !== 0 || M_Addr !== 16'h0 || M_DataIn !== 16'h0) begin
      errors++;
      $display("FAIL hold_idle: got wr=%b addr=%h din=%h, want 0 0000 0000", M_Wr, M_Addr, M_DataIn);
    end
  endtask

  task automatic test_random();
    int starve;
    int lat;
    logic grant_d, exp_rd, exp_wr, exp_idone, exp_ddone;
    logic [15:0] exp_addr, exp_din, mdata;
    starve = 0;
    for (int t = 0; t < 40; t++) begin
      if (!IReq && $urandom_range(0, 1) == 1) begin IReq = 1; IAddr = 16'($urandom); end
      if (!DRd && !DWr && $urandom_range(0, 1) == 1) begin
        if ($urandom_range(0, 1) == 1) DRd = 1; else DWr = 1;
        DAddr = 16'($urandom); DDataIn = 16'($urandom);
      end
      if (!IReq && !DRd && !DWr) begin IReq = 1; IAddr = 16'($urandom); end
      DDump = 1'($urandom_range(0, 1));
      M_err = 1'($urandom_range(0, 1));
      #1;
      checks++;
      if (M_Rd !== 0 || M_Wr !== 0 || M_Addr !== 16'h0 || err !== 0 || M_Dump !== DDump ||
          IDone !== 0 || DDone !== 0) begin
        errors++;
        $display("FAIL rand_idle%0d: got rd=%b wr=%b addr=%h err=%b dump=%b idone=%b ddone=%b",
                 t, M_Rd, M_Wr, M_Addr, err, M_Dump, IDone, DDone);
      end
      grant_d  = (DRd || DWr) && (starve < int'(STARVE_LIMIT));
      exp_addr = grant_d ? DAddr : IAddr;
      exp_din  = DDataIn;
      exp_rd   = grant_d ? DRd : 1'b1;
      exp_wr   = grant_d ? DWr : 1'b0;
      if (grant_d) starve = IReq ? starve + 1 : 0;
      else starve = 0;
      tick();
      lat = $urandom_range(0, 3);
      mdata = '0;
      for (int w = 0; w <= lat; w++) begin
        if (grant_d) begin
          DAddr = 16'($urandom); DDataIn = 16'($urandom);
          if (!IReq && $urandom_range(0, 3) == 0) begin IReq = 1; IAddr = 16'($urandom); end
        end else begin
          IAddr = 16'($urandom);
          if (!DRd && !DWr && $urandom_range(0, 3) == 0) begin
            DRd = 1; DAddr = 16'($urandom); DDataIn = 16'($urandom);
          end
        end
        M_err = 1'($urandom_range(0, 1));
        if (w == lat) begin mdata = 16'($urandom); M_Done = 1; M_DataOut = mdata; end
        else M_DataOut = 16'($urandom);
        exp_idone = !grant_d && (w == lat);
        exp_ddone = grant_d && (w == lat);
        #1;
        checks++;
        if (M_Addr !== exp_addr || M_Rd !== exp_rd || M_Wr !== exp_wr ||
            (grant_d && M_DataIn !== exp_din) || err !== M_err) begin
          errors++;
          $display("FAIL rand_mem%0d_%0d: got addr=%h rd=%b wr=%b din=%h err=%b, want %h %b %b %h %b",
                   t, w, M_Addr, M_Rd, M_Wr, M_DataIn, err, exp_addr, exp_rd, exp_wr, exp_din, M_err);
        end
        checks++;
        if (IDone !== exp_idone || DDone !== exp_ddone ||
            IDataOut !== (exp_idone ? mdata : 16'h0) || DDataOut !== (exp_ddone ? mdata : 16'h0) ||
            IStall !== (IReq && !exp_idone) || DStall !== ((DRd || DWr) && !exp_ddone)) begin
          errors++;
          $display("FAIL rand_resp%0d_%0d: got idone=%b ddone=%b idata=%h ddata=%h istall=%b dstall=%b, want idone=%b ddone=%b data=%h",
                   t, w, IDone, DDone, IDataOut, DDataOut, IStall, DStall, exp_idone, exp_ddone, mdata);
        end
        tick();
      end
      M_Done = 0; M_err = 0; M_DataOut = '0;
      if (grant_d) begin DRd = 0; DWr = 0; end
      else IReq = 0;
    end
    idle_inputs();
  endtask

  task automatic test_watchdog();
    DRd = 1; DAddr = 16'h0400; M_DataOut = 16'hA5A5;
    tick();
    for (int k = 1; k <= int'(TIMEOUT); k++) begin
      checks++;
      if (DDone !== (k == int'(TIMEOUT)) || DDataOut !== 16'h0 || M_Rd !== 1) begin
        errors++;
        $display("FAIL wdog_cycle%0d: got ddone=%b ddata=%h rd=%b, want %b 0000 1",
                 k, DDone, DDataOut, M_Rd, k == int'(TIMEOUT));
      end
      if (k < int'(TIMEOUT)) tick();
    end
    tick();
    DRd = 0; M_DataOut = '0; #1;
    checks++;
    if (err !== 1 || DDone !== 0 || M_Rd !== 0) begin
      errors++;
      $display("FAIL wdog_after: got err=%b ddone=%b rd=%b, want 1 0 0", err, DDone, M_Rd);
    end
    repeat (3) tick();
    checks++;
    if (err !== 1) begin
      errors++;
      $display("FAIL wdog_sticky: got err=%b want 1", err);
    end
  endtask

  task automatic test_reset_mid();
    DWr = 1; DAddr = 16'h0500; DDataIn = 16'h1111;
    tick();
    checks++;
    if (M_Wr !== 1 || M_Addr !== 16'h0500 || err !== 1) begin
      errors++;
      $display("FAIL rstmid_busy: got wr=%b addr=%h err=%b, want 1 0500 1", M_Wr, M_Addr, err);
    end
    rst = 1; #1;
    checks++;
    if (M_Wr !== 0 || M_Addr !== 16'h0 || DDone !== 0 || err !== 0) begin
      errors++;
      $display("FAIL rstmid_abort: got wr=%b addr=%h ddone=%b err=%b, want 0 0000 0 0",
               M_Wr, M_Addr, DDone, err);
    end
    tick();
    rst = 0; DWr = 0;
    tick();
    checks++;
    if (M_Wr !== 0 || DDone !== 0 || err !== 0) begin
      errors++;
      $display("FAIL rstmid_idle: got wr=%b ddone=%b err=%b, want 0 0 0", M_Wr, DDone, err);
    end
  endtask

  initial begin
    rst = 1;
    idle_inputs();
    @(negedge clk);
    test_reset();
    test_single_fetch();
    test_priority();
    test_starvation();
    test_hold_latch();
    test_random();
    test_watchdog();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
